// File: rtl/tlb_lookup.sv
// Fully associative Sv39 TLB in front of the page-table walker; misses walk, fill, then hit.
// Define TLB_PERF_EN to add the hit_cnt/miss_cnt performance counter outputs.
module tlb_lookup #(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_en,
    input  logic [63:0] req_va,
    input  logic [63:0] satp,
    input  logic [1:0]  mmode,
    input  logic        flush,
    output logic        req_done,
    output logic [63:0] req_pa,
    output logic        walk_en,
    output logic [63:0] walk_va,
    input  logic        walk_done,
    input  logic [63:0] walk_pa
`ifdef TLB_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WALK, FILL} state_e;

    state_e                 state_q, state_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [26:0]            vpn_q [NUM_ENTRIES];
    logic [43:0]            ppn_q [NUM_ENTRIES];
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [63:0]            satp_q;
    logic [63:0]            walk_va_q;
    logic [43:0]            walk_ppn_q;
    logic                   discard_q, discard_d;

    logic                   bare;
    logic                   inval;
    logic                   hit;
    logic                   start_walk;
    logic                   fill_we;
    logic                   have_free;
    logic [IDX_W-1:0]       victim;
    logic [43:0]            hit_ppn;
    logic [NUM_ENTRIES-1:0] match;
    logic [NUM_ENTRIES-1:0] fill_match;
    logic                   unused_bits;

    assign bare       = !req_en || (satp[63:60] == 4'd0) || (mmode == 2'b11);
    assign inval      = flush || (satp != satp_q);
    assign hit        = !bare && (state_q == IDLE) && (|match);
    assign start_walk = (state_q == IDLE) && !bare && !hit;
    // A discarded walk or a same-cycle invalidation must leave the entry invalid.
    assign fill_we    = (state_q == FILL) && !discard_q && !inval && !(|fill_match);
    assign unused_bits = ^{req_va[63:39], walk_pa[63:56], walk_pa[11:0]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cam
            assign match[gi]      = valid_q[gi] && (vpn_q[gi] == req_va[38:12]);
            assign fill_match[gi] = valid_q[gi] && (vpn_q[gi] == walk_va_q[38:12]);
        end
    endgenerate

    // At most one entry matches, so OR-ing the selected PPNs acts as a mux.
    always_comb begin
        hit_ppn = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (match[i]) begin
                hit_ppn = hit_ppn | ppn_q[i];
            end
        end
    end

    always_comb begin
        victim    = rr_q;
        have_free = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim    = IDX_W'(i);
                have_free = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (inval) begin
            valid_d = '0;
        end else if (fill_we) begin
            valid_d[victim] = 1'b1;
        end
    end

    assign rr_d = (fill_we && !have_free) ? rr_q + 1'b1 : rr_q;

    always_comb begin
        discard_d = discard_q;
        if (start_walk) begin
            discard_d = 1'b0;
        end else if ((state_q != IDLE) && inval) begin
            discard_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_walk) state_d = WALK;
            WALK:    if (walk_done) state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        walk_en  = (state_q == WALK);
        walk_va  = walk_va_q;
        req_done = 1'b0;
        req_pa   = '0;
        if (bare) begin
            req_done = req_en;
            req_pa   = req_va;
        end else if (hit) begin
            req_done = 1'b1;
            req_pa   = {8'b0, hit_ppn, req_va[11:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            rr_q       <= '0;
            satp_q     <= '0;
            walk_va_q  <= '0;
            walk_ppn_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rr_q      <= rr_d;
            satp_q    <= satp;
            discard_q <= discard_d;
            if (start_walk) begin
                walk_va_q <= req_va;
            end
            if ((state_q == WALK) && walk_done) begin
                walk_ppn_q <= walk_pa[55:12];
            end
        end
    end

    // Tag/data storage needs no reset; valid_q gates every use.
    always_ff @(posedge clk) begin
        if (!reset && fill_we) begin
            vpn_q[victim] <= walk_va_q[38:12];
            ppn_q[victim] <= walk_ppn_q;
        end
    end

`ifdef TLB_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (start_walk) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_lookup.sv
// Scoreboard bench for tlb_lookup with a fixed-latency walker model.
module tb_tlb_lookup;

    localparam int WALK_LAT = 6;
    localparam int MISS_LAT = WALK_LAT + 2;
    localparam int TIMEOUT  = 200;
    localparam logic [63:0] SATP1 = 64'h8000_0000_0008_0000;
    localparam logic [63:0] SATP2 = 64'h8000_0000_0009_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_en;
    logic [63:0] req_va;
    logic [63:0] satp;
    logic [1:0]  mmode;
    logic        flush;
    logic        req_done;
    logic [63:0] req_pa;
    logic        walk_en;
    logic [63:0] walk_va;
    logic        walk_done;
    logic [63:0] walk_pa;
`ifdef TLB_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int walk_starts = 0;
    int walk_cnt = 0;
    logic walk_en_prev = 1'b0;

    typedef struct {
        logic [63:0] va;
        logic [63:0] pa;
        int          lat;
    } txn_t;
    txn_t sb[$];

    tlb_lookup #(.NUM_ENTRIES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_en    (req_en),
        .req_va    (req_va),
        .satp      (satp),
        .mmode     (mmode),
        .flush     (flush),
        .req_done  (req_done),
        .req_pa    (req_pa),
        .walk_en   (walk_en),
        .walk_va   (walk_va),
        .walk_done (walk_done),
        .walk_pa   (walk_pa)
`ifdef TLB_PERF_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [43:0] ppn_of(input logic [26:0] vpn);
        if (vpn == 27'h401) return 44'h87654;
        return {17'h1, vpn ^ 27'h02a_5a5a};
    endfunction

    function automatic logic [63:0] pa_of(input logic [63:0] va);
        return {8'h0, ppn_of(va[38:12]), va[11:0]};
    endfunction

    // Walker: done on the WALK_LAT-th cycle of walk_en, cleared once walk_en drops.
    always @(negedge clk) begin
        if (walk_en && !walk_en_prev) walk_starts = walk_starts + 1;
        walk_en_prev = walk_en;
        if (walk_en) begin
            walk_cnt = walk_cnt + 1;
            walk_done = (walk_cnt == WALK_LAT);
            walk_pa   = pa_of(walk_va);
        end else begin
            walk_cnt  = 0;
            walk_done = 1'b0;
            walk_pa   = '0;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pulse;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
    endtask

    // Drives one request; flush is pulsed during request cycle flush_at (-1: never).
    task automatic request(input string name, input logic [63:0] va, input logic [63:0] exp_pa,
                           input int exp_lat, input int flush_at);
        txn_t t;
        txn_t exp_t;
        int lat;
        bit got;
        t.va = va; t.pa = exp_pa; t.lat = exp_lat;
        sb.push_back(t);
        req_en = 1'b1;
        req_va = va;
        lat = 0;
        got = 1'b0;
        while (!got && lat <= TIMEOUT) begin
            flush = (lat == flush_at);
            @(negedge clk);
            if (req_done) got = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        flush = 1'b0;
        exp_t = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: va=%h req_done never seen (required within %0d cycles)", name, va, TIMEOUT);
        end else begin
            if (req_pa !== exp_t.pa) begin
                errors++;
                $display("FAIL %s pa: va=%h got %h required %h", name, va, req_pa, exp_t.pa);
            end
            checks++;
            if (lat != exp_t.lat) begin
                errors++;
                $display("FAIL %s latency: va=%h got %0d required %0d", name, va, lat, exp_t.lat);
            end
            $display("txn %s va=%h pa=%h lat=%0d", name, va, req_pa, lat);
        end
        step();
        req_en = 1'b0;
        step();
    endtask

    task automatic test_reset;
        reset = 1'b1; req_en = 1'b0; req_va = '0; satp = '0; mmode = 2'b00; flush = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (walk_en !== 1'b0 || req_done !== 1'b0) begin
            errors++;
            $display("FAIL reset ctl: walk_en=%b req_done=%b required 0 0", walk_en, req_done);
        end
        checks++;
        if (walk_va !== 64'h0 || req_pa !== 64'h0) begin
            errors++;
            $display("FAIL reset data: walk_va=%h req_pa=%h required 0 0", walk_va, req_pa);
        end
`ifdef TLB_PERF_EN
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset perf: hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
        end
`endif
        step();
    endtask

    task automatic test_bare;
        int starts0;
        starts0 = walk_starts;
        satp = '0;
        request("bare_satp0", 64'h8000_1234, 64'h8000_1234, 0, -1);
        satp = SATP1; mmode = 2'b11;
        step();
        request("bare_mmode3", 64'h0123_4567_89ab_cdef, 64'h0123_4567_89ab_cdef, 0, -1);
        mmode = 2'b00;
        checks++;
        if (walk_starts != starts0) begin
            errors++;
            $display("FAIL bare_walk: walks got %0d required 0", walk_starts - starts0);
        end
        step();
    endtask

    task automatic test_miss_hit;
        int starts0;
        starts0 = walk_starts;
        request("miss", 64'h0040_1abc, 64'h8765_4abc, MISS_LAT, -1);
        request("hit", 64'h0040_1def, 64'h8765_4def, 0, -1);
        checks++;
        if (walk_starts - starts0 != 1) begin
            errors++;
            $display("FAIL miss_hit_walks: got %0d required 1", walk_starts - starts0);
        end
    endtask

    task automatic test_replacement;
        logic [63:0] va;
        flush_pulse();
        for (int i = 0; i < 9; i++) begin
            va = 64'((64'h100 + i) << 12) | 64'h010;
            request("repl_fill", va, pa_of(va), MISS_LAT, -1);
        end
        for (int i = 1; i < 9; i++) begin
            va = 64'((64'h100 + i) << 12) | 64'h020;
            request("repl_hit", va, pa_of(va), 0, -1);
        end
        va = 64'h0010_0030;
        request("repl_evicted", va, pa_of(va), MISS_LAT, -1);
    endtask

    task automatic test_flush;
        flush_pulse();
        request("flush_fill", 64'h0040_1000, 64'h8765_4000, MISS_LAT, -1);
        request("flush_prehit", 64'h0040_1000, 64'h8765_4000, 0, -1);
        flush_pulse();
        request("flush_miss", 64'h0040_1000, 64'h8765_4000, MISS_LAT, -1);
        satp = SATP2;
        step();
        request("satp_miss", 64'h0040_1000, 64'h8765_4000, MISS_LAT, -1);
    endtask

    task automatic test_flush_during_walk;
        int starts0;
        flush_pulse();
        starts0 = walk_starts;
        request("flush_walk", 64'h0012_3456, pa_of(64'h0012_3456), 2 * MISS_LAT, 3);
        checks++;
        if (walk_starts - starts0 != 2) begin
            errors++;
            $display("FAIL flush_walk_rewalk: walks got %0d required 2", walk_starts - starts0);
        end
        request("flush_walk_hit", 64'h0012_3004, pa_of(64'h0012_3004), 0, -1);
    endtask

    task automatic test_reset_mid_walk;
        request("rst_fill", 64'h0055_5000, pa_of(64'h0055_5000), MISS_LAT, -1);
        req_en = 1'b1;
        req_va = 64'h0066_6000;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (walk_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_prewalk: walk_en got %b required 1", walk_en);
        end
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (walk_en !== 1'b0 || req_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_midwalk: walk_en=%b req_done=%b required 0 0", walk_en, req_done);
        end
`ifdef TLB_PERF_EN
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            errors++;
            $display("FAIL rst_midwalk_perf: hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt);
        end
`endif
        req_en = 1'b0;
        step();
        reset = 1'b0;
        step();
        request("rst_invalid", 64'h0055_5000, pa_of(64'h0055_5000), MISS_LAT, -1);
    endtask

    initial begin
        walk_done = 1'b0;
        walk_pa   = '0;
        test_reset();
        test_bare();
        satp = SATP1;
        mmode = 2'b00;
        repeat (2) step();
        test_miss_hit();
        test_replacement();
        test_flush();
        test_flush_during_walk();
        test_reset_mid_walk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_lookup.md
Name: tlb_lookup

Overview:
- Fully associative Sv39 TLB placed directly upstream of the page-table walker, `translate`.
- Fetch and memory stages present a VA; on a hit it returns the PA combinationally in the same cycle.
- On a miss it drives the walker's en/va until the walker reports done, fills an entry, then answers from the TLB.
- Bare-mode accesses bypass it.

Parameters:
- NUM_ENTRIES, 8, number of fully associative entries (power of two, 2..32).
- IDX_W, $clog2(NUM_ENTRIES), entry index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_en  in  1  translation requested; held high by the requester until req_done.
- req_va  in  64  virtual address; stable while req_en is high.
- satp  in  64  current satp CSR value.
- mmode  in  2  current privilege mode.
- flush  in  1  sfence.vma pulse; invalidates all entries.
- req_done  out  1  translation available this cycle.
- req_pa  out  64  physical address, valid when req_done.
- walk_en  out  1  drives `translate` en.
- walk_va  out  64  drives `translate` va.
- walk_done  in  1  from `translate` done.
- walk_pa  in  64  from `translate` pa.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state=IDLE.
  - All valid bits 0, replacement pointer 0, satp_q=0.
  - walk_en=0, walk_va=0, req_done=0, req_pa=0.
- Bare condition: bare = !req_en || satp[63:60]==0 || mmode==2'b11.
  - When bare: req_done=req_en and req_pa=req_va, combinationally.
  - No lookup, no walk, no fill.
- Entry contents: valid, vpn[26:0]=va[38:12], ppn[43:0]=pa[55:12].
- Hit:
  - hit = !bare && state==IDLE && some valid entry has vpn==req_va[38:12].
  - Only one entry may match; fills never duplicate a VPN already present.
  - On hit: req_done=1 and req_pa={8'b0, ppn, req_va[11:0]} in the same cycle (0-cycle latency).
- State machine:
  - IDLE:
    - On req_en && !bare && !hit, go to WALK.
    - Latch walk_va=req_va.
  - WALK:
    - walk_en=1.
    - On walk_done, capture walk_pa[55:12], go to FILL.
  - FILL:
    - walk_en=0 for exactly one cycle, so the walker returns to its IDLE.
    - Write the entry unless the fill is discarded.
    - Go to IDLE. The next cycle hits.
  - Miss latency: walker latency + 2 cycles from req_en to req_done.
- Victim selection:
  - Use the lowest-index invalid entry if any exists.
  - Otherwise use the round-robin pointer, which increments mod NUM_ENTRIES on each such fill.
- Invalidation:
  - flush=1 clears all valid bits at the next edge.
  - satp != satp_q clears all valid bits at the next edge; satp_q tracks satp every cycle.
  - A flush or satp change while in WALK or FILL sets the discard flag.
  - When discard is set, the FILL write is suppressed and the FSM still returns to IDLE.
  - The request then misses again and re-walks.
  - Flush in the same cycle as a FILL write: flush wins, and the entry ends invalid.
- Request dropped: if req_en falls during WALK, wait for walk_done, fill normally, then go to IDLE.
- Reset mid-walk: everything returns to reset values next cycle. The walker also sees walk_en=0.
- Page faults are ignored; walk_pa is trusted as-is.

Optional Feature:
- TLB_PERF_EN defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Both reset to 0 and wrap at 2^32.
  - hit_cnt increments on each cycle with req_done && !bare && state==IDLE.
  - miss_cnt increments on each IDLE->WALK transition.
- TLB_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Bare passthrough: satp=0, req_en=1, req_va=0x8000_1234 -> req_done=1 same cycle, req_pa=0x8000_1234, walk_en stays 0.
2. Miss then hit:
   - Stimulus: satp=0x8000_0000_0008_0000, mmode=0, va=0x0040_1abc; walker returns walk_pa=0x8765_4abc after 6 cycles.
   - Required: walk_en high until walk_done, then a 1-cycle low; req_done at cycle 8 with pa=0x8765_4abc.
   - A repeat of va=0x0040_1def hits in 0 cycles with pa=0x8765_4def.
3. Replacement:
   - Stimulus: fill 9 distinct VPNs with NUM_ENTRIES=8.
   - Required: the 9th evicts entry 0 (the first VPN, which now misses), and VPNs 2..9 hit.
4. Flush:
   - Stimulus: a flush pulse after filling VPN 0x401.
   - Required: the next request to 0x0040_1000 misses. Changing satp to 0x8000_0000_0009_0000 also invalidates all entries.
5. Flush during WALK:
   - Stimulus: assert flush while walk_en=1.
   - Required: the FILL write is suppressed; the same VA re-walks, a second walk_en assertion is seen, and the correct pa is then returned.
6. Reset mid-walk:
   - Stimulus: assert reset in WALK.
   - Required: next cycle walk_en=0, req_done=0, all entries invalid; with TLB_PERF_EN, hit_cnt=miss_cnt=0.
